// File: rtl/rr_arb16.sv
// Sixteen-way round-robin arbiter with grant hold and hold-limit pre-emption; 1-cycle request-to-grant.
// Outputs decode from registered state only; an owner keeps the grant while its request stays high.
module rr_arb16 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_valid
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [3:0] HOLD_LAST  = 4'((MAX_HOLD + 15) % 16);
   localparam logic       PREEMPT_EN = (MAX_HOLD != 0);

   state_t      r_state;
   logic [3:0]  r_owner;
   logic [3:0]  r_ptr;
   logic [3:0]  r_hold;

   logic [15:0] w_owner_bit;
   logic [15:0] w_req_oth;
   logic        w_all_vld;
   logic [3:0]  w_all_idx;
   logic        w_oth_vld;
   logic [3:0]  w_oth_idx;
   logic        w_do_grant;
   logic [3:0]  w_gidx;
   logic        w_to_idle;

   // First set bit of mask scanning upward from start, wrapping at 15.
   function automatic logic [4:0] pick(input logic [15:0] mask, input logic [3:0] start);
      logic [4:0] res;
      logic [3:0] k;
      res = '0;
      for (int i = 15; i >= 0; i--) begin
         k = start + 4'(i);
         if (mask[k]) res = {1'b1, k};
      end
      return res;
   endfunction

   assign w_owner_bit            = 16'h0001 << r_owner;
   assign w_req_oth              = req & ~w_owner_bit;
   assign {w_all_vld, w_all_idx} = pick(req, r_ptr);
   assign {w_oth_vld, w_oth_idx} = pick(w_req_oth, r_ptr);

   always_comb begin
      w_do_grant = 1'b0;
      w_gidx     = '0;
      w_to_idle  = 1'b0;
      if (!en) begin
         w_to_idle = 1'b1;
      end else if (r_state == ST_IDLE) begin
         w_do_grant = w_all_vld;
         w_gidx     = w_all_idx;
      end else if (!req[r_owner]) begin
         w_do_grant = w_oth_vld;
         w_gidx     = w_oth_idx;
         w_to_idle  = !w_oth_vld;
      end else if (PREEMPT_EN && (r_hold == HOLD_LAST) && w_oth_vld) begin
         w_do_grant = 1'b1;
         w_gidx     = w_oth_idx;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_hold  <= '0;
      end else if (w_do_grant) begin
         r_state <= ST_BUSY;
         r_owner <= w_gidx;
         r_ptr   <= w_gidx + 4'd1;
         r_hold  <= '0;
      end else if (w_to_idle) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
      end else if ((r_state == ST_BUSY) && (r_hold != 4'hF)) begin
         r_hold  <= r_hold + 4'd1;
      end
   end

   assign gnt_valid = (r_state == ST_BUSY);
   assign gnt_idx   = gnt_valid ? r_owner : 4'd0;
   assign gnt       = gnt_valid ? w_owner_bit : 16'h0000;

endmodule

// File: tb/tb_rr_arb16.sv
// Bench for rr_arb16: directed scenarios followed by random traffic, all checked
// against an integer-level round-robin model.
module tb_rr_arb16;

   localparam int MH = 3;

   logic        clk;
   logic        resetn;
   logic        en;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;

   int n_tot = 0;
   int n_bad = 0;

   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_hold;

   int rot_exp [6] = '{15, 0, 1, 15, 0, 1};

   rr_arb16 #(.MAX_HOLD(MH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int pick(input logic [15:0] m, input int start);
      int k;
      for (int i = 0; i < 16; i++) begin
         k = (start + i) % 16;
         if (m[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_hold  = 0;
   endtask

   task automatic model_grant(input int k);
      m_busy  = 1'b1;
      m_owner = k;
      m_ptr   = (k + 1) % 16;
      m_hold  = 0;
   endtask

   task automatic model_edge();
      int k;
      logic [15:0] oth;
      oth = req;
      oth[m_owner] = 1'b0;
      if (!en) begin
         m_busy = 1'b0;
         m_hold = 0;
      end else if (!m_busy) begin
         k = pick(req, m_ptr);
         if (k >= 0) model_grant(k);
      end else if (!req[m_owner]) begin
         k = pick(oth, m_ptr);
         if (k >= 0) model_grant(k);
         else m_busy = 1'b0;
      end else if (MH != 0 && m_hold == MH - 1 && oth != 16'h0) begin
         model_grant(pick(oth, m_ptr));
      end else if (m_hold < 15) begin
         m_hold++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_busy));
      chk({tag, ".idx"}, 32'(gnt_idx), m_busy ? 32'(m_owner) : 32'd0);
      chk({tag, ".gnt"}, 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk_model(tag);
   endtask

   initial begin
      resetn = 1'b0;
      en     = 1'b1;
      req    = 16'h0010;
      model_reset();
      #2;
      chk_model("por");
      chk("por.gnt_zero", 32'(gnt), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      tick("first");
      chk("first.idx", 32'(gnt_idx), 32'd4);
      chk("first.gnt", 32'(gnt), 32'h0010);

      // Rotation: the current owner drops its bit each cycle, others keep theirs.
      for (int i = 0; i < 6; i++) begin
         req = 16'h8003;
         req[m_owner] = 1'b0;
         tick("rot");
         chk("rot.order", 32'(gnt_idx), 32'(rot_exp[i]));
         chk("rot.noidle", 32'(gnt_valid), 32'd1);
      end

      req = 16'h8000;
      tick("wrap15");
      chk("wrap15.idx", 32'(gnt_idx), 32'd15);
      req = 16'h8001;
      tick("wrap.hold");
      chk("wrap.hold.idx", 32'(gnt_idx), 32'd15);
      req = 16'h0001;
      tick("wrap0");
      chk("wrap0.idx", 32'(gnt_idx), 32'd0);
      req = 16'h8000;
      tick("wrap.back");
      chk("wrap.back.idx", 32'(gnt_idx), 32'd15);

      req = 16'h0004;
      tick("pre.own2");
      chk("pre.own2.idx", 32'(gnt_idx), 32'd2);
      req = 16'h0024;
      for (int i = 0; i < 2; i++) begin
         tick("pre.hold");
         chk("pre.hold.idx", 32'(gnt_idx), 32'd2);
      end
      tick("pre.switch");
      chk("pre.switch.idx", 32'(gnt_idx), 32'd5);
      req = 16'h0004;
      tick("pre.regain");
      chk("pre.regain.idx", 32'(gnt_idx), 32'd2);

      req = 16'h0080;
      for (int i = 0; i < 20; i++) begin
         tick("solo");
         chk("solo.gnt", 32'(gnt), 32'h0080);
      end

      req = 16'h0200;
      tick("en.own9");
      chk("en.own9.idx", 32'(gnt_idx), 32'd9);
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick("en.off");
         chk("en.off.gnt", 32'(gnt), 32'd0);
      end
      en  = 1'b1;
      req = 16'h0600;
      tick("en.back");
      chk("en.back.idx", 32'(gnt_idx), 32'd10);
      tick("en.busy");
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      chk_model("rst.mid");
      chk("rst.mid.gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      tick("rst.ptr0");
      chk("rst.ptr0.idx", 32'(gnt_idx), 32'd9);

      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 3) == 0) req = 16'($urandom() & $urandom());
         if (m_busy && $urandom_range(0, 2) == 0) req[m_owner] = 1'b0;
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_arb16.md
# rr_arb16

Sixteen-way round-robin arbiter that shares a single 4-to-16 decoded select resource among sixteen requesters. Each cycle it owns the 4-bit select index and its decoder enable. It grants one requester at a time, holds the grant while that requester keeps its request asserted, and rotates priority fairly. It also pre-empts an owner that exceeds a configurable hold limit while others wait. The one-hot grant output is the decoded form of the granted index and drives the per-requester select lines downstream.

## Interface
- MAX_HOLD, 8: maximum consecutive BUSY cycles for one owner while other requests are pending; legal 0..15; 0 disables pre-emption.
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- en  input  1  arbiter enable; when low, grants are withdrawn.
- req  input  16  request vector; bit k is requester k, level-sensitive, held high until service is complete.
- gnt  output  16  one-hot grant, the decoded form of gnt_idx gated by gnt_valid; all zero when gnt_valid=0.
- gnt_idx  output  4  index of the current owner; 0 when gnt_valid=0.
- gnt_valid  output  1  a grant is active.

## Operation
- Registered state:
  - state: IDLE or BUSY.
  - owner[3:0].
  - ptr[3:0]: search start, the highest-priority index.
  - hold[3:0]: cycles the current owner has held.
- Outputs decode from registered state only; there is no combinational path from req or en to outputs.
- Search function pick(mask):
  - First set bit of mask, scanning ptr, ptr+1, … 15, 0, … ptr−1 (mod 16).
  - "none" if mask is all zero.
- Every grant to index k sets owner=k, ptr=(k+1) mod 16, hold=0 and state=BUSY.
- Priority of next-state rules, evaluated at each rising edge:
  1. en=0: state→IDLE, hold→0; ptr and owner unchanged.
  2. IDLE: if pick(req) returns k, grant k; else remain IDLE.
  3. BUSY, req[owner]=0 (release):
     - If pick(req with owner bit cleared) returns k, grant k (back-to-back, no idle cycle).
     - Otherwise state→IDLE.
  4. BUSY, req[owner]=1, MAX_HOLD≠0, hold=MAX_HOLD−1, and some other req bit set (pre-empt):
     - Grant pick(req with owner bit cleared).
     - The pre-empted requester keeps its request and re-competes under round-robin.
  5. BUSY, req[owner]=1, otherwise: hold increments, saturating at 15; owner unchanged.
- Width rules:
  - ptr and owner wrap modulo 16; index 15+1 → 0.
  - The hold compare is 4-bit unsigned.
- Owner never changes while req[owner]=1 unless rule 1 or rule 4 applies.

## Timing
- Reset, asynchronous, any time including mid-grant:
  - state=IDLE, owner=0, ptr=0, hold=0.
  - gnt=16'h0000, gnt_idx=0, gnt_valid=0, immediately and without waiting for clk.
- Reset release: first arbitration occurs at the first rising edge with resetn=1.
- Request-to-grant latency: 1 cycle. req sampled at edge N makes gnt visible after edge N.
- Release-to-next-grant: 1 cycle. The owner drops req before edge N; after edge N the new owner is granted and the old grant is removed in the same update.
- Pre-emption: an owner with competitors is granted for exactly MAX_HOLD cycles.
- Disable: en low at edge N clears gnt after edge N. Re-arbitration after en returns high starts from the retained ptr.
- Simultaneous release and new request from the same requester in the same cycle: treated as continuous hold, since req is level-sensitive.

## Test plan
- Reset, then single requester:
  - Stimulus: resetn low mid-cycle with req=16'h0010, then release reset.
  - Required: all outputs 0 asynchronously during reset. After the first edge, gnt=16'h0010, gnt_idx=4, gnt_valid=1.
- Round-robin rotation:
  - Stimulus: req=16'h8003 held; each owner drops its bit for one cycle after being granted, then re-raises it.
  - Required: grant order 0,1,15,0,1,… with back-to-back grants and no idle cycles.
- Wrap-around:
  - Stimulus: grant index 15 first (ptr becomes 0), then req=16'h8001.
  - Required: after 15 releases, grant goes to index 0 before 15 again.
- Pre-emption:
  - Stimulus: MAX_HOLD=3; requester 2 holds continuously; req[5] rises while 2 owns.
  - Required: 2 owns exactly 3 cycles, then gnt_idx=5. Requester 2 regains the grant after 5 releases.
- No pre-emption without competitors:
  - Stimulus: MAX_HOLD=3; only req[7] held for 20 cycles.
  - Required: gnt_idx=7 throughout; hold saturates at 15 with no glitch on gnt.
- Enable and reset mid-operation:
  - Stimulus: owner 9; deassert en for 2 cycles; re-enable with req=16'h0600; then assert resetn low during BUSY.
  - Required: gnt=0 while en is low. After re-enable, grant goes to 10 (ptr=10). Reset clears everything asynchronously and ptr returns to 0.
